bram_stream_reader: RTL

- Read-side controller for the 2K x 8 dual-port byte buffer. The writer fills the buffer through port A and publishes its write pointer.
- This block drains the buffer through the registered read port (dpra/dpo) and presents bytes as a valid/ready stream toward the host interface.
- It returns its read pointer so the writer can compute free space.
- Single clock domain: the buffer's read-port clock is tied to clk.

---
 rtl/bram_stream_reader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - read-side prefetch controller for the dual-port byte buffer
//
// Drains the byte buffer through its registered read port and presents the
// bytes as a valid/ready stream. A two-entry skid FIFO absorbs the one-cycle
// read latency, so the stream sustains one byte per cycle and never stalls a
// fetch that is already in flight.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   wr_ptr            writer pointer including wrap bit
//   rd_addr           buffer read address (dpra), taken from the fetch pointer
//   rd_data           buffer read data (dpo), valid the cycle after rd_addr
//   dout, dout_valid  output byte stream, driven from the skid FIFO head
//   dout_ready        consumer ready
//   rd_ptr            consumed pointer including wrap bit, returned to the writer
//   fill, empty       wr_ptr - rd_ptr and its zero flag
//   flush             discard all unread data in one cycle
//   overflow          sticky: writer got more than one buffer depth ahead
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  empty,
  input  logic                  flush,
  output logic                  overflow
);

  // Fetch pointer: runs ahead of rd_ptr by (skid entries + in-flight read).
  logic [ADDR_WIDTH:0]   fp;
  logic                  inflight;

  // Two-entry skid FIFO: head index plus occupancy count.
  logic [DATA_WIDTH-1:0] skid [2];
  logic                  head;
  logic [1:0]            count;

  logic                  pop;
  logic                  avail;
  logic                  issue;
  logic [1:0]            occupancy;
  logic                  wr_slot;
  logic                  fill_over;

  always_comb begin
    pop        = 1'b0;
    avail      = 1'b0;
    occupancy  = 2'd0;
    issue      = 1'b0;
    wr_slot    = 1'b0;
    fill_over  = 1'b0;
    dout_valid = (count != 2'd0);
    dout       = '0;
    rd_addr    = fp[ADDR_WIDTH-1:0];
    fill       = wr_ptr - rd_ptr;
    empty      = (fill == '0);

    if (dout_valid) begin
      dout = skid[head];
    end

    pop   = dout_valid && dout_ready;
    avail = (wr_ptr != fp);
    // Slots committed after this edge; count + inflight never exceeds 2 and
    // pop implies count >= 1, so two bits cannot wrap.
    occupancy = count + {1'b0, inflight} - {1'b0, pop};
    issue     = avail && (occupancy < 2'd2);
    // Next free slot is head + count (mod 2). A push only happens with
    // count <= 1, so this never lands on a live entry.
    wr_slot   = head ^ count[0];
    // fill > 2**ADDR_WIDTH: top bit set with any lower bit set.
    fill_over = fill[ADDR_WIDTH] && (fill[ADDR_WIDTH-1:0] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fp       <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
      skid[0]  <= '0;
      skid[1]  <= '0;
    end else if (flush) begin
      // Resynchronise both pointers to the writer; whatever is in flight or
      // buffered is dropped, including a byte handed off this same cycle.
      fp       <= wr_ptr;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (issue) begin
        fp <= fp + 1'b1;
      end
      inflight <= issue;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        head   <= ~head;
      end
      if (inflight) begin
        skid[wr_slot] <= rd_data;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (fill_over) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
